// File: rtl/factorial_engine.sv
// factorial_engine
//
// Iterative factorial engine, controller and datapath together. An operand
// is captured under load, n! is formed with one multiply per clock in
// descending order (n, n-1, ..., 2), and the product is presented under a
// done/dack handshake. A product that no longer fits RESULT_WIDTH bits
// saturates to all ones and raises ovf.
//
// State table:
//   state | meaning
//   IDLE  | ready for load; result holds the last product
//   START | operand captured; repeated load recaptures it
//   COMP  | one multiply (or the terminal check) per cycle
//   VALID | result/ovf valid, waiting for dack
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   load   in   operand strobe (IDLE/START)
//   n_in   in   operand, N_WIDTH bits, unsigned
//   abort  in   cancel computation (START/COMP)
//   dack   in   result acknowledge (VALID)
//   pre    out  idle, ready for load
//   acc    out  busy (START or COMP)
//   done   out  result/ovf valid
//   result out  product register, RESULT_WIDTH bits
//   ovf    out  last computation overflowed; result saturated

module factorial_engine #(
    parameter int N_WIDTH      = 8,
    parameter int RESULT_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [N_WIDTH-1:0]      n_in,
    input  logic                    abort,
    input  logic                    dack,
    output logic                    pre,
    output logic                    acc,
    output logic                    done,
    output logic [RESULT_WIDTH-1:0] result,
    output logic                    ovf
);

    localparam int FULL_WIDTH = RESULT_WIDTH + N_WIDTH;

    localparam logic [N_WIDTH-1:0]      CNT_ONE  = {{(N_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RESULT_WIDTH-1:0] PROD_ONE = {{(RESULT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_COMP  = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t                  state, state_nx;
    logic [N_WIDTH-1:0]      cnt, cnt_nx;
    logic [RESULT_WIDTH-1:0] prod, prod_nx;
    logic                    ovf_q, ovf_nx;
    logic [FULL_WIDTH-1:0]   full_prod;
    logic                    prod_overflow;

    // Both operands are widened first so the product is computed at full
    // width and the bits above RESULT_WIDTH reveal an overflow.
    assign full_prod     = {{N_WIDTH{1'b0}}, prod} * {{RESULT_WIDTH{1'b0}}, cnt};
    assign prod_overflow = (full_prod[FULL_WIDTH-1:RESULT_WIDTH] != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            prod  <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            prod  <= prod_nx;
            ovf_q <= ovf_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        prod_nx  = prod;
        ovf_nx   = ovf_q;
        unique case (state)
            S_IDLE: begin
                if (load) begin
                    state_nx = S_START;
                    cnt_nx   = n_in;
                    prod_nx  = PROD_ONE;
                    ovf_nx   = 1'b0;
                end
            end
            S_START: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (load) begin
                    cnt_nx = n_in;
                end else begin
                    state_nx = S_COMP;
                end
            end
            S_COMP: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (cnt <= CNT_ONE) begin
                    state_nx = S_VALID;
                end else if (prod_overflow) begin
                    prod_nx  = '1;
                    ovf_nx   = 1'b1;
                    state_nx = S_VALID;
                end else begin
                    prod_nx = full_prod[RESULT_WIDTH-1:0];
                    cnt_nx  = cnt - CNT_ONE;
                end
            end
            S_VALID: begin
                if (dack) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign pre    = (state == S_IDLE);
    assign acc    = (state == S_START) || (state == S_COMP);
    assign done   = (state == S_VALID);
    assign result = prod;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_factorial_engine.sv
// tb_factorial_engine
//
// Self-checking bench for factorial_engine with default widths. Directed
// sequences plus randomized operands and handshake delays; expected product,
// overflow flag and busy-cycle count come from a plain-arithmetic factorial
// model. Inputs change and outputs are sampled on the falling edge.

module tb_factorial_engine;

    localparam int NW = 8;
    localparam int RW = 64;

    logic          clk;
    logic          rst;
    logic          load;
    logic [NW-1:0] n_in;
    logic          abort;
    logic          dack;
    logic          pre;
    logic          acc;
    logic          done;
    logic [RW-1:0] result;
    logic          ovf;

    int n_checks;
    int n_errors;

    factorial_engine #(.N_WIDTH(NW), .RESULT_WIDTH(RW)) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .n_in   (n_in),
        .abort  (abort),
        .dack   (dack),
        .pre    (pre),
        .acc    (acc),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // n! by plain arithmetic, descending multiply order. busy counts the
    // START cycle plus every COMP cycle: each multiply evaluated (the
    // overflowing one included) or, without overflow, n-1 multiplies and
    // one terminal check.
    function automatic void model(input int n, output logic [RW-1:0] r,
                                  output logic o, output int busy);
        logic [127:0] p;
        int           muls;
        p    = 128'd1;
        o    = 1'b0;
        muls = 0;
        for (int i = n; i >= 2; i--) begin
            muls++;
            p = p * i;
            if ((p >> RW) != 0) begin
                o    = 1'b1;
                r    = '1;
                busy = 1 + muls;
                return;
            end
        end
        r    = p[RW-1:0];
        busy = 1 + ((n < 1) ? 1 : n);
    endfunction

    // Called on a falling edge in the first START cycle. Counts busy cycles
    // until done, then checks the result.
    task automatic finish_op(input string tag, input int n);
        logic [RW-1:0] er;
        logic          eo;
        int            eb;
        int            busy;
        int            guard;
        model(n, er, eo, eb);
        busy  = 0;
        guard = 0;
        while (!done && guard < 600) begin
            if (acc) busy++;
            guard++;
            @(negedge clk);
        end
        chk({tag, " done"}, RW'(done), RW'(1));
        chk({tag, " busy"}, RW'(busy), RW'(eb));
        chk({tag, " result"}, result, er);
        chk({tag, " ovf"}, RW'(ovf), RW'(eo));
    endtask

    // Hold off dack for wait_cycles VALID cycles (with ignored load/abort
    // noise), then acknowledge and check the return to IDLE.
    task automatic ack_op(input string tag, input int wait_cycles);
        logic [RW-1:0] r0;
        logic          o0;
        r0 = result;
        o0 = ovf;
        for (int i = 0; i < wait_cycles; i++) begin
            load  = 1'($urandom_range(0, 1));
            abort = 1'($urandom_range(0, 1));
            n_in  = NW'($urandom_range(0, 255));
            @(negedge clk);
            chk({tag, " hold done"}, RW'(done), RW'(1));
            chk({tag, " hold result"}, result, r0);
            chk({tag, " hold ovf"}, RW'(ovf), RW'(o0));
        end
        load  = 1'b0;
        abort = 1'b0;
        dack  = 1'b1;
        @(negedge clk);
        dack = 1'b0;
        chk({tag, " ack pre"}, RW'(pre), RW'(1));
        chk({tag, " ack done"}, RW'(done), RW'(0));
        chk({tag, " ack keep"}, result, r0);
    endtask

    task automatic start_op(input int n);
        load = 1'b1;
        n_in = NW'(n);
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int n;
        int done_cnt;
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        load  = 1'b0;
        n_in  = '0;
        abort = 1'b0;
        dack  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst pre", RW'(pre), RW'(1));
        chk("rst acc", RW'(acc), RW'(0));
        chk("rst done", RW'(done), RW'(0));
        chk("rst result", result, '0);
        chk("rst ovf", RW'(ovf), RW'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle pre", RW'(pre), RW'(1));

        // basic, boundary and overflow operands
        start_op(5);   finish_op("n5", 5);   ack_op("n5", 0);
        chk("n5 value", result, 64'd120);
        start_op(0);   finish_op("n0", 0);   ack_op("n0", 1);
        start_op(1);   finish_op("n1", 1);   ack_op("n1", 0);
        start_op(20);  finish_op("n20", 20); ack_op("n20", 0);
        chk("n20 value", result, 64'd2432902008176640000);
        start_op(21);  finish_op("n21", 21); ack_op("n21", 0);
        chk("n21 sat", result, 64'hFFFF_FFFF_FFFF_FFFF);

        // load held over several cycles: last sampled operand wins
        load = 1'b1; n_in = 8'd9; @(negedge clk);
        n_in = 8'd4; @(negedge clk);
        n_in = 8'd6; @(negedge clk);
        load = 1'b0;
        chk("reload start", RW'(acc), RW'(1));
        finish_op("reload", 6); ack_op("reload", 0);
        chk("reload value", result, 64'd720);

        // abort on the third COMP cycle
        start_op(10);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort pre", RW'(pre), RW'(1));
        chk("abort acc", RW'(acc), RW'(0));
        done_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort no done", RW'(done_cnt), RW'(0));
        start_op(3); finish_op("post abort", 3); ack_op("post abort", 0);

        // long dack wait with ignored load/abort
        start_op(4); finish_op("n4", 4); ack_op("n4", 10);
        chk("n4 value", result, 64'd24);

        // dack held high: exactly one VALID cycle
        dack = 1'b1;
        start_op(3);
        done_cnt = 0;
        repeat (12) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        dack = 1'b0;
        chk("dack held valid cycles", RW'(done_cnt), RW'(1));
        chk("dack held pre", RW'(pre), RW'(1));
        chk("dack held result", result, 64'd6);

        // reset mid-COMP
        start_op(10);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst pre", RW'(pre), RW'(1));
        chk("midrst result", result, '0);
        chk("midrst ovf", RW'(ovf), RW'(0));
        @(negedge clk);
        chk("midrst idle", RW'(pre), RW'(1));

        // randomized operands and handshake delays
        for (int k = 0; k < 25; k++) begin
            n = (k % 5 == 4) ? int'($urandom_range(22, 255)) : int'($urandom_range(0, 24));
            start_op(n);
            finish_op($sformatf("rnd%0d n=%0d", k, n), n);
            ack_op($sformatf("rnd%0d", k), int'($urandom_range(0, 4)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/factorial_engine.md
# factorial_engine

- Parametrised iterative factorial engine: controller and datapath in one block.
- Accepts an operand `n` under a `load` strobe and computes `n!` with one multiply per clock.
- Presents the result under a `done`/`dack` handshake.
- Adds over the previous controller-only engine: configurable widths, internal termination (no external `stop`), overflow detection with saturation, and an `abort` path.

## Interface

- `N_WIDTH`, 8: width of operand `n_in`.
- `RESULT_WIDTH`, 64: width of product register and `result`; must be ≥ `N_WIDTH`.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `load`  in  1  operand strobe; `n_in` sampled every cycle `load`=1 in IDLE/START.
- `n_in`  in  `N_WIDTH`  operand, unsigned.
- `abort`  in  1  cancel computation; effective in START/COMP only.
- `dack`  in  1  result acknowledge; effective in VALID only.
- `pre`  out  1  engine idle, ready for `load`.
- `acc`  out  1  engine busy (START or COMP).
- `done`  out  1  `result`/`ovf` valid.
- `result`  out  `RESULT_WIDTH`  product register, driven continuously.
- `ovf`  out  1  last computation overflowed; `result` saturated.

## Operation

- States: IDLE, START, COMP, VALID. Unreachable encodings return to IDLE.
- `pre`=(IDLE), `acc`=(START|COMP), `done`=(VALID). All are decoded from registered state only.
- IDLE:
  - `load`=1 → START; capture `cnt`←`n_in`, `prod`←1, `ovf`←0.
  - Otherwise hold. `abort` and `dack` are ignored.
- START:
  - `abort`=1 → IDLE. `abort` beats `load`.
  - Else `load`=1 → START; recapture `cnt`←`n_in`, so the last sampled value wins.
  - Else → COMP.
- COMP, evaluated in this priority order:
  - `abort`=1 → IDLE; `prod`/`ovf` left as-is.
  - Else `cnt`≤1 → VALID; `prod` unchanged.
  - Else the full product `prod*cnt` is `RESULT_WIDTH+N_WIDTH` bits wide.
    - If its upper `N_WIDTH` bits ≠0: `prod`←all ones, `ovf`←1, → VALID.
    - Otherwise: `prod`←low `RESULT_WIDTH` bits, `cnt`←`cnt`−1, stay COMP.
  - `load` is ignored in COMP.
- VALID:
  - `dack`=1 → IDLE. Otherwise hold.
  - `load` and `abort` are ignored.
  - `result`/`ovf` are stable for the whole VALID interval.
- `result` keeps its value through IDLE after `dack`, until the next IDLE→START capture sets it to 1.
- Multiply order is descending: n, n−1, …, 2.

## Timing

- Reset values: state IDLE, `pre`=1, `acc`=0, `done`=0, `result`=0, `ovf`=0, `cnt`=0.
- Reset wins over every input in every state, including mid-COMP and VALID. The first cycle after `rst` deasserts is IDLE.
- Cycle count with single-cycle `load` in cycle T (IDLE):
  - START in T+1. COMP from T+2.
  - COMP lasts max(n,1) cycles without overflow: n−1 multiplies plus one terminal check.
  - First VALID cycle (`done`=1) is T+2+max(n,1).
- Overflow exits COMP in the cycle the overflowing multiply is evaluated. VALID follows on the next cycle.
- `dack` sampled in VALID cycle V → IDLE at V+1, with `pre`=1. `load` is accepted from V+1.
- `abort` sampled in START/COMP cycle A → IDLE at A+1.
- `dack` may be held high permanently. The engine then spends exactly one cycle in VALID.

## Test plan

1. Reset, then `load`=1 for one cycle with `n_in`=5 → `acc` high for 6 cycles, then `done`=1, `result`=120, `ovf`=0. `dack` → `pre`=1 next cycle.
2. `n_in`=0, then `n_in`=1 → each gives a single COMP cycle, `result`=1, `ovf`=0.
3. Default widths, `n_in`=20 → `result`=2432902008176640000, `ovf`=0. Then `n_in`=21 → `result`=0xFFFF_FFFF_FFFF_FFFF, `ovf`=1, with `done` before the multiply count completes.
4. `load` held 3 cycles with `n_in`=9, 4, 6 → result 720 (6!). COMP entered one cycle after `load` falls.
5. `n_in`=10, `abort` on the 3rd COMP cycle → IDLE next cycle, `done` never asserts. A following `n_in`=3 gives `result`=6.
6. `n_in`=4, `dack` withheld 10 cycles → `done`/`result`=24 stable all 10 cycles, with `load` pulses ignored. Separately, `rst` mid-COMP → IDLE, `result`=0, `ovf`=0 next cycle.
